dram_refresh_sched: RTL
=======================

DRAM_REFRESH_SCHED -- requirements
Module: dram_refresh_sched

Interface
REQ-001 SHALL have parameter TREFI, default 10, meaning refresh interval in CLK cycles (TREFI >= 2).
REQ-002 SHALL have parameter TRFC, default 10, meaning refresh busy time in CLK cycles (TRFC >= 1).
REQ-003 SHALL have parameter MAX_POSTPONE, default 8, meaning the maximum number of owed refreshes (1..15).
REQ-004 SHALL have port CLK  input  1  system clock, rising-edge.
REQ-005 SHALL have port nRST  input  1  asynchronous active-low reset.
REQ-006 SHALL have port refresh_en  input  1  enables interval counting.
REQ-007 SHALL have port ref_ack  input  1  command FSM issued REFRESH this cycle.
REQ-008 SHALL have port ref_req  output  1  refresh owed and may be issued.
REQ-009 SHALL have port ref_urgent  output  1  postpone limit reached; FSM must refresh before the next ACTIVATE.
REQ-010 SHALL have port ref_busy  output  1  tRFC window active; no commands to rank.
REQ-011 SHALL have port pending_cnt  output  4  number of owed refreshes.
REQ-012 SHALL have port ref_overflow  output  1  sticky flag: interval expired while at the limit.

Function
REQ-013 SHALL keep an interval counter that increments each cycle refresh_en=1, wraps from TREFI-1 to 0, and generates a one-cycle internal tick on the wrap.
REQ-014 SHALL clear the interval counter to 0 on any cycle refresh_en=0, and SHALL retain pending_cnt while refresh_en=0.
REQ-015 SHALL increment pending_cnt on a tick, saturating at MAX_POSTPONE.
REQ-016 SHALL set ref_overflow on a tick when pending_cnt=MAX_POSTPONE with no accepted ack, and SHALL hold it set until reset.
REQ-017 SHALL implement a state machine with two states, RUN and BUSY, and SHALL reset to RUN.
REQ-018 SHALL drive ref_req=1 iff state=RUN and pending_cnt!=0 (registered-state combinational).
REQ-019 SHALL accept ref_ack only when ref_req=1, and SHALL ignore ref_ack otherwise with no state change.
REQ-020 On an accepted ack, SHALL decrement pending_cnt, move RUN->BUSY, and load the tRFC counter with TRFC-1.
REQ-021 SHALL leave pending_cnt unchanged when an accepted ack and a tick occur in the same cycle, including at MAX_POSTPONE (no overflow).
REQ-022 SHALL drive ref_busy=1 in BUSY for exactly TRFC cycles, starting the cycle after the ack, and SHALL then return to RUN.
REQ-023 SHALL let the interval counter and ticks continue during BUSY.
REQ-024 SHALL drive ref_urgent=1 iff pending_cnt>=MAX_POSTPONE.

Reset
REQ-025 On nRST=0, SHALL immediately drive ref_req, ref_urgent, ref_busy, ref_overflow=0 and pending_cnt=0, with state=RUN and all counters at 0, including mid-BUSY.
REQ-026 SHALL start counting on the first rising CLK edge after nRST deasserts with refresh_en=1.

Configuration
REQ-027 With macro REF_STATS_EN defined, SHALL add output port ref_count (16 bits) counting accepted acks, saturating at 16'hFFFF and reset to 0.
REQ-028 With REF_STATS_EN undefined, SHALL have no ref_count port and no statistics logic.

Verification
REQ-029 Reset release, refresh_en=1 held, no ack -> ref_req rises after 10 enabled edges, pending_cnt=1.
REQ-030 pending_cnt=1, ack while ref_req=1 -> next cycle pending_cnt=0, ref_busy=1 for 10 cycles, ref_req=0 throughout, then RUN.
REQ-031 No ack for 80 enabled cycles -> pending_cnt=8, ref_urgent=1; at cycle 90 -> ref_overflow=1, pending_cnt stays 8.
REQ-032 pending_cnt=3, ack coincident with tick -> pending_cnt stays 3, state=BUSY.
REQ-033 Ack while ref_req=0, then nRST pulsed mid-BUSY -> ack ignored; after the pulse, all outputs=0 asynchronously, state=RUN.
REQ-034 REF_STATS_EN defined, three accepted acks spaced >TRFC apart -> ref_count=3.

Source files
------------

// File: rtl/dram_refresh_sched.sv
// dram_refresh_sched: tracks owed DRAM refreshes and paces the tRFC busy window.
// An interval counter ticks every TREFI enabled cycles and each tick adds one owed
// refresh, up to MAX_POSTPONE. The command FSM takes refreshes through ref_req/ref_ack.
// Optional macro REF_STATS_EN adds a saturating 16-bit count of accepted refreshes.
module dram_refresh_sched #(
  parameter int TREFI        = 10,
  parameter int TRFC         = 10,
  parameter int MAX_POSTPONE = 8
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       refresh_en,
  input  logic       ref_ack,
  output logic       ref_req,
  output logic       ref_urgent,
  output logic       ref_busy,
  output logic [3:0] pending_cnt,
`ifdef REF_STATS_EN
  output logic [15:0] ref_count,
`endif
  output logic       ref_overflow
);

  localparam int IW = (TREFI > 2) ? $clog2(TREFI) : 1;
  localparam int RW = (TRFC > 2) ? $clog2(TRFC) : 1;
  localparam logic [IW-1:0] INTERVAL_LAST = IW'(TREFI - 1);
  localparam logic [RW-1:0] RFC_LOAD      = RW'(TRFC - 1);
  localparam logic [3:0]    PENDING_MAX   = 4'(MAX_POSTPONE);

  typedef enum logic {RUN, BUSY} state_t;

  state_t        state;
  logic [IW-1:0] interval_cnt;
  logic [RW-1:0] rfc_cnt;
  logic          tick;
  logic          ack_ok;

  // Outputs decoded from registered state; an ack is only honoured while a refresh is offered.
  always_comb begin
    tick       = refresh_en && (interval_cnt == INTERVAL_LAST);
    ref_req    = (state == RUN) && (pending_cnt != 4'd0);
    ack_ok     = ref_ack && ref_req;
    ref_busy   = (state == BUSY);
    ref_urgent = (pending_cnt >= PENDING_MAX);
  end

  // Interval counter: runs while enabled (including during BUSY), restarts whenever disabled.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      interval_cnt <= '0;
    end else if (!refresh_en || tick) begin
      interval_cnt <= '0;
    end else begin
      interval_cnt <= interval_cnt + 1'b1;
    end
  end

  // Owed-refresh bookkeeping; a coincident tick and accepted ack cancel each other out.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pending_cnt  <= 4'd0;
      ref_overflow <= 1'b0;
    end else begin
      if (ack_ok && !tick) begin
        pending_cnt <= pending_cnt - 4'd1;
      end else if (tick && !ack_ok && !ref_urgent) begin
        pending_cnt <= pending_cnt + 4'd1;
      end
      if (tick && !ack_ok && ref_urgent) begin
        ref_overflow <= 1'b1;
      end
    end
  end

  // RUN/BUSY sequencer: an accepted ack opens a TRFC-cycle busy window.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= RUN;
      rfc_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (ack_ok) begin
            state   <= BUSY;
            rfc_cnt <= RFC_LOAD;
          end
        end
        BUSY: begin
          if (rfc_cnt == '0) begin
            state <= RUN;
          end else begin
            rfc_cnt <= rfc_cnt - 1'b1;
          end
        end
        default: begin
          state   <= RUN;
          rfc_cnt <= '0;
        end
      endcase
    end
  end

`ifdef REF_STATS_EN
  // Saturating count of refreshes actually issued.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ref_count <= 16'd0;
    end else if (ack_ok && (ref_count != 16'hFFFF)) begin
      ref_count <= ref_count + 16'd1;
    end
  end
`endif

endmodule
